// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 16-bit LFSR state-word pattern.
// Seeds its reference from the incoming stream, verifies a run of good words,
// then free-runs the reference and flags/counts mismatching words while locked.
module lfsr_checker #(
  parameter int                    DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] C_POLYNOM     = 16'hB400,
  parameter int                    LOCK_CNT      = 4,
  parameter int                    LOSS_CNT      = 3,
  parameter int                    ERR_CNT_WIDTH = 32
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_clr_cnt,
  output logic                     out_locked,
  output logic                     out_err,
  output logic [ERR_CNT_WIDTH-1:0] out_err_cnt
);

  // Counter widths sized so LOCK_CNT / LOSS_CNT themselves are representable.
  localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int BW = (LOSS_CNT < 1) ? 1 : $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_CNT);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);
  localparam logic [BW-1:0] BAD_ONE   = BW'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    ref_q, ref_d;
  logic [MW-1:0]            match_cnt_q, match_cnt_d;
  logic [BW-1:0]            bad_cnt_q, bad_cnt_d;
  logic                     locked_q, locked_d;
  logic                     err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // One step of the generator's Fibonacci LFSR: shift left, feed back tap parity.
  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-2:0], ^(x & C_POLYNOM)};
  endfunction

  logic data_match;
  logic data_zero;
  assign data_match = (in_data == ref_q);
  assign data_zero  = (in_data == '0);

  // Next-state logic: lock FSM, reference advance, run counters and error count.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // The all-zero word is the LFSR lock-up state and can never seed.
          if (!data_zero) begin
            ref_d       = lfsr_next(in_data);
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end

        VERIFY: begin
          if (data_match) begin
            ref_d       = lfsr_next(in_data);
            match_cnt_d = match_cnt_q + MATCH_ONE;
            if (match_cnt_q + MATCH_ONE == LOCK_LAST) begin
              state_d   = LOCKED;
              bad_cnt_d = '0;
              locked_d  = 1'b1;
            end
          end else if (data_zero) begin
            match_cnt_d = '0;
            state_d     = HUNT;
          end else begin
            // Treat the unexpected word as a fresh seed.
            ref_d       = lfsr_next(in_data);
            match_cnt_d = '0;
          end
        end

        LOCKED: begin
          // Free-running reference: a corrupted word never disturbs the sequence.
          ref_d = lfsr_next(ref_q);
          if (data_match) begin
            bad_cnt_d = '0;
          end else begin
            err_d     = 1'b1;
            bad_cnt_d = bad_cnt_q + BAD_ONE;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end
            if (bad_cnt_q + BAD_ONE == LOSS_LAST) begin
              state_d     = HUNT;
              match_cnt_d = '0;
              bad_cnt_d   = '0;
              locked_d    = 1'b0;
            end
          end
        end

        default: begin
          state_d     = HUNT;
          match_cnt_d = '0;
          bad_cnt_d   = '0;
          locked_d    = 1'b0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; the error pulse is unaffected.
    if (in_clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  // State register with asynchronous reset so lock drops immediately on reset.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= HUNT;
      ref_q       <= '0;
      match_cnt_q <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_locked  = locked_q;
  assign out_err     = err_q;
  assign out_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: directed word stream with a scoreboard queue of
// expected {locked, err, err_cnt} per valid word, checked by a monitor process.
module tb_lfsr_checker;

  localparam int CW = 4;

  logic          clk;
  logic          in_rst;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_clr_cnt;
  logic          out_locked;
  logic          out_err;
  logic [CW-1:0] out_err_cnt;

  lfsr_checker #(
    .DATA_WIDTH   (16),
    .C_POLYNOM    (16'hB400),
    .LOCK_CNT     (4),
    .LOSS_CNT     (3),
    .ERR_CNT_WIDTH(CW)
  ) dut (
    .in_clk     (clk),
    .in_rst     (in_rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_clr_cnt (in_clr_cnt),
    .out_locked (out_locked),
    .out_err    (out_err),
    .out_err_cnt(out_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int txn;
  logic [5:0]  exp_q[$];
  logic [15:0] cur;
  logic        pend;

  // Remembers that the edge just taken consumed a valid word.
  always_ff @(posedge clk or posedge in_rst) begin
    if (in_rst) pend <= 1'b0;
    else        pend <= in_valid;
  end

  function automatic logic [15:0] f(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%0h expected=%0h", name, txn, act, exp);
    end
  endtask

  task automatic monitor();
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (pend) begin
        txn++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output txn=%0d got=output expected=none", txn);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: locked=%0b err=%0b cnt=%0d (exp %0b %0b %0d)",
                   txn, out_locked, out_err, out_err_cnt, e[5], e[4], e[3:0]);
          chk("locked",  {31'd0, out_locked}, {31'd0, e[5]});
          chk("err",     {31'd0, out_err},    {31'd0, e[4]});
          chk("err_cnt", {28'd0, out_err_cnt}, {28'd0, e[3:0]});
        end
      end else begin
        chk("idle_err", {31'd0, out_err}, 32'd0);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic el, input logic ee,
                           input logic [CW-1:0] ec, input logic clr);
    in_valid   = 1'b1;
    in_data    = d;
    in_clr_cnt = clr;
    exp_q.push_back({el, ee, ec});
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_clr_cnt = 1'b0;
  endtask

  task automatic good(input logic el, input logic [CW-1:0] ec);
    send_word(cur, el, 1'b0, ec, 1'b0);
    cur = f(cur);
  endtask

  task automatic bad(input logic el, input logic [CW-1:0] ec, input logic clr);
    send_word(cur ^ 16'h0001, el, 1'b1, ec, clr);
    cur = f(cur);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int gaps[5] = '{3, 0, 5, 1, 2};

  initial begin
    checks = 0; errors = 0; txn = 0;
    in_rst = 1'b1; in_valid = 1'b0; in_data = '0; in_clr_cnt = 1'b0; cur = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked",  {31'd0, out_locked}, 32'd0);
    chk("rst_err",     {31'd0, out_err},    32'd0);
    chk("rst_err_cnt", {28'd0, out_err_cnt}, 32'd0);
    in_rst = 1'b0;

    // Zero word in HUNT, then lock acquisition on a contiguous stream.
    send_word(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
    send_word(16'hAAAA, 1'b0, 1'b0, 4'd0, 1'b0);
    send_word(16'h5554, 1'b0, 1'b0, 4'd0, 1'b0);
    send_word(16'hAAA8, 1'b0, 1'b0, 4'd0, 1'b0);
    cur = f(16'hAAA8);
    good(1'b0, 4'd0);
    good(1'b1, 4'd0);

    // Single bit flip while locked.
    bad(1'b1, 4'd1, 1'b0);
    repeat (3) good(1'b1, 4'd1);

    // A good word between bad ones restarts the loss run.
    bad(1'b1, 4'd2, 1'b0);
    bad(1'b1, 4'd3, 1'b0);
    good(1'b1, 4'd3);
    bad(1'b1, 4'd4, 1'b0);
    bad(1'b1, 4'd5, 1'b0);
    good(1'b1, 4'd5);

    // Loss of lock, then relock after 5 words.
    bad(1'b1, 4'd6, 1'b0);
    bad(1'b1, 4'd7, 1'b0);
    bad(1'b0, 4'd8, 1'b0);
    repeat (4) good(1'b0, 4'd8);
    good(1'b1, 4'd8);

    // Drop lock, then a sequence jump during VERIFY restarts the match count.
    bad(1'b1, 4'd9, 1'b0);
    bad(1'b1, 4'd10, 1'b0);
    bad(1'b0, 4'd11, 1'b0);
    repeat (3) good(1'b0, 4'd11);
    cur = 16'h1234;
    good(1'b0, 4'd11);
    repeat (3) good(1'b0, 4'd11);
    good(1'b1, 4'd11);

    // Drop lock, then gapped stream relocks on the 5th valid word.
    bad(1'b1, 4'd12, 1'b0);
    bad(1'b1, 4'd13, 1'b0);
    bad(1'b0, 4'd14, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(gaps[i]);
      good(i == 4, 4'd14);
    end

    // Clear together with an error: count 0, pulse still present.
    bad(1'b1, 4'd0, 1'b1);
    good(1'b1, 4'd0);

    // Saturation at all-ones after 20 errors.
    for (int i = 1; i <= 20; i++) begin
      bad(1'b1, (i > 15) ? 4'd15 : CW'(i), 1'b0);
      good(1'b1, (i > 15) ? 4'd15 : CW'(i));
    end

    // Clear on an idle cycle keeps lock.
    in_clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    in_clr_cnt = 1'b0;
    good(1'b1, 4'd0);
    bad(1'b1, 4'd1, 1'b0);
    idle(1);

    // Asynchronous reset mid-lock clears outputs before any clock edge.
    #2;
    in_rst = 1'b1;
    #1;
    chk("async_rst_locked",  {31'd0, out_locked}, 32'd0);
    chk("async_rst_err_cnt", {28'd0, out_err_cnt}, 32'd0);
    chk("async_rst_err",     {31'd0, out_err},    32'd0);
    @(posedge clk);
    #1;
    in_rst = 1'b0;
    repeat (4) good(1'b0, 4'd0);
    good(1'b1, 4'd0);

    idle(3);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
